pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline registers (PC, ID, EXE, MEM, WB). It drives every stage register's Wr/Flush pair from four sources: cache busy, load-use hazard, multi-cycle divide and redirect (exception, branch). It holds a divider cycle counter and a pending-redirect state machine, so a redirect that arrives during a fetch stall is never lost.

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the PC/ID/EXE/MEM/WB pipeline registers.
// Arbitrates exceptions, cache stalls, multi-cycle divide, load-use and branch redirects.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ICache_Busy,
  input  logic       DCache_Busy,
  input  logic       EXE_IsLoad,
  input  logic [4:0] EXE_Dst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       EXE_IsDiv,
  input  logic       EXE_BrRedirect,
  input  logic       MEM_ExcValid,
  output logic       PC_Wr,
  output logic       ID_Wr,
  output logic       ID_Flush,
  output logic       EXE_Wr,
  output logic       EXE_Flush,
  output logic       MEM_Wr,
  output logic       MEM_Flush,
  output logic       WB_Wr,
  output logic       WB_Flush,
  output logic       PC_SelExc,
  output logic       PC_SelBr,
  output logic       Div_Start,
  output logic       Div_Busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, EXC_PEND, BR_PEND} redir_state_e;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_e;

  redir_state_e     redir_q, redir_d;
  div_state_e       div_q, div_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  logic exc_take, load_use, div_stall, br_req, any_stall;

  // A fresh exception waits while MEM is stalled on the D-cache; a pending one always wins.
  always_comb begin
    exc_take  = (MEM_ExcValid && !DCache_Busy) || (redir_q == EXC_PEND);
    load_use  = EXE_IsLoad && (EXE_Dst != 5'd0) &&
                ((EXE_Dst == ID_rs) || (EXE_Dst == ID_rt));
    div_stall = (div_q == D_RUN) || ((div_q == D_IDLE) && EXE_IsDiv);
    br_req    = EXE_BrRedirect || (redir_q == BR_PEND);
    any_stall = DCache_Busy || div_stall || load_use || ICache_Busy;
  end

  // NOTE: every output is given a default before the priority chain so no path infers a latch.
  always_comb begin
    PC_Wr     = 1'b1;
    ID_Wr     = 1'b1;
    ID_Flush  = 1'b0;
    EXE_Wr    = 1'b1;
    EXE_Flush = 1'b0;
    MEM_Wr    = 1'b1;
    MEM_Flush = 1'b0;
    WB_Wr     = 1'b1;
    WB_Flush  = 1'b0;
    PC_SelExc = 1'b0;
    PC_SelBr  = 1'b0;
    Div_Start = 1'b0;
    Div_Busy  = (div_q == D_RUN);
    if (exc_take) begin
      ID_Flush  = 1'b1;
      EXE_Flush = 1'b1;
      MEM_Flush = 1'b1;
      if (ICache_Busy) PC_Wr     = 1'b0;
      else             PC_SelExc = 1'b1;
    end else if (DCache_Busy) begin
      PC_Wr    = 1'b0;
      ID_Wr    = 1'b0;
      EXE_Wr   = 1'b0;
      MEM_Wr   = 1'b0;
      WB_Flush = 1'b1;
    end else if (div_stall) begin
      PC_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EXE_Wr    = 1'b0;
      MEM_Flush = 1'b1;
      Div_Start = (div_q == D_IDLE);
    end else if (load_use) begin
      PC_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EXE_Flush = 1'b1;
    end else if (ICache_Busy) begin
      PC_Wr    = 1'b0;
      ID_Flush = 1'b1;
    end else if (br_req) begin
      PC_SelBr = 1'b1;
      ID_Flush = 1'b1;
    end
  end

  always_comb begin
    redir_d   = redir_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    if (exc_take) begin
      redir_d   = ICache_Busy ? EXC_PEND : IDLE;
      div_d     = D_IDLE;
      div_cnt_d = '0;
    end else begin
      if (br_req) redir_d = any_stall ? BR_PEND : IDLE;
      // A D-cache stall freezes the divider so its EXE occupancy stays exact.
      if (!DCache_Busy) begin
        case (div_q)
          D_IDLE: if (EXE_IsDiv) begin
            div_d     = D_RUN;
            div_cnt_d = CNT_W'(DIV_CYCLES - 1);
          end
          D_RUN: begin
            div_cnt_d = div_cnt_q - 1'b1;
            if (div_cnt_q <= CNT_W'(1)) div_d = D_DONE;
          end
          D_DONE:  div_d = D_IDLE;
          default: div_d = D_IDLE;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redir_q   <= IDLE;
      div_q     <= D_IDLE;
      div_cnt_q <= '0;
    end else begin
      redir_q   <= redir_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then randomized traffic,
// all compared against a stage-action reference model.
module tb_pipe_hazard_ctrl;

  localparam int DIV_CYCLES = 12;

  localparam int B_PC_WR = 12, B_ID_WR = 11, B_ID_FL = 10, B_EXE_WR = 9, B_EXE_FL = 8;
  localparam int B_MEM_WR = 7, B_MEM_FL = 6, B_WB_WR = 5, B_WB_FL = 4;
  localparam int B_SEL_EXC = 3, B_SEL_BR = 2, B_DIV_START = 1, B_DIV_BUSY = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       ICache_Busy, DCache_Busy, EXE_IsLoad, EXE_IsDiv, EXE_BrRedirect, MEM_ExcValid;
  logic [4:0] EXE_Dst, ID_rs, ID_rt;
  logic       PC_Wr, ID_Wr, ID_Flush, EXE_Wr, EXE_Flush, MEM_Wr, MEM_Flush;
  logic       WB_Wr, WB_Flush, PC_SelExc, PC_SelBr, Div_Start, Div_Busy;

  pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) u_dut (
    .clk(clk), .rst(rst),
    .ICache_Busy(ICache_Busy), .DCache_Busy(DCache_Busy),
    .EXE_IsLoad(EXE_IsLoad), .EXE_Dst(EXE_Dst), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .EXE_IsDiv(EXE_IsDiv), .EXE_BrRedirect(EXE_BrRedirect), .MEM_ExcValid(MEM_ExcValid),
    .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .ID_Flush(ID_Flush), .EXE_Wr(EXE_Wr), .EXE_Flush(EXE_Flush),
    .MEM_Wr(MEM_Wr), .MEM_Flush(MEM_Flush), .WB_Wr(WB_Wr), .WB_Flush(WB_Flush),
    .PC_SelExc(PC_SelExc), .PC_SelBr(PC_SelBr), .Div_Start(Div_Start), .Div_Busy(Div_Busy)
  );

  always #5 clk = ~clk;

  logic [12:0] got_v, exp_v, last_v;
  assign got_v = {PC_Wr, ID_Wr, ID_Flush, EXE_Wr, EXE_Flush, MEM_Wr, MEM_Flush,
                  WB_Wr, WB_Flush, PC_SelExc, PC_SelBr, Div_Start, Div_Busy};

  int checks = 0;
  int failures = 0;

  // Reference model: pending-redirect flags plus remaining divide busy cycles.
  typedef enum logic [1:0] {ADV, HOLD, BUB} act_e;
  bit m_exc_pend, m_br_pend, m_div_done;
  int m_div_left;
  bit n_exc_pend, n_br_pend, n_div_done;
  int n_div_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_exc_pend = 1'b0;
    m_br_pend  = 1'b0;
    m_div_done = 1'b0;
    m_div_left = 0;
  endtask

  task automatic model_eval();
    act_e act [5];
    bit exc, div_idle, div_hold, lu, br, stalled;
    foreach (act[i]) act[i] = ADV;
    div_idle = (m_div_left == 0) && !m_div_done;
    exc      = (MEM_ExcValid && !DCache_Busy) || m_exc_pend;
    div_hold = (m_div_left > 0) || (div_idle && EXE_IsDiv);
    lu       = EXE_IsLoad && (EXE_Dst != 0) && ((EXE_Dst == ID_rs) || (EXE_Dst == ID_rt));
    br       = EXE_BrRedirect || m_br_pend;
    stalled  = DCache_Busy || div_hold || lu || ICache_Busy;
    // Stage order in act[]: PC, ID, EXE, MEM, WB.
    if (exc) begin
      act[0] = ICache_Busy ? HOLD : ADV;
      act[1] = BUB; act[2] = BUB; act[3] = BUB;
    end else if (DCache_Busy) begin
      act[0] = HOLD; act[1] = HOLD; act[2] = HOLD; act[3] = HOLD; act[4] = BUB;
    end else if (div_hold) begin
      act[0] = HOLD; act[1] = HOLD; act[2] = HOLD; act[3] = BUB;
    end else if (lu) begin
      act[0] = HOLD; act[1] = HOLD; act[2] = BUB;
    end else if (ICache_Busy) begin
      act[0] = HOLD; act[1] = BUB;
    end else if (br) begin
      act[1] = BUB;
    end
    exp_v = '0;
    exp_v[B_PC_WR]     = (act[0] != HOLD);
    exp_v[B_ID_WR]     = (act[1] != HOLD);
    exp_v[B_ID_FL]     = (act[1] == BUB);
    exp_v[B_EXE_WR]    = (act[2] != HOLD);
    exp_v[B_EXE_FL]    = (act[2] == BUB);
    exp_v[B_MEM_WR]    = (act[3] != HOLD);
    exp_v[B_MEM_FL]    = (act[3] == BUB);
    exp_v[B_WB_WR]     = (act[4] != HOLD);
    exp_v[B_WB_FL]     = (act[4] == BUB);
    exp_v[B_SEL_EXC]   = exc && !ICache_Busy;
    exp_v[B_SEL_BR]    = !exc && br && !stalled;
    exp_v[B_DIV_START] = !exc && !DCache_Busy && div_idle && EXE_IsDiv;
    exp_v[B_DIV_BUSY]  = (m_div_left > 0);

    n_exc_pend = m_exc_pend; n_br_pend = m_br_pend;
    n_div_done = m_div_done; n_div_left = m_div_left;
    if (exc) begin
      n_exc_pend = ICache_Busy;
      n_br_pend  = 1'b0;
      n_div_left = 0;
      n_div_done = 1'b0;
    end else begin
      if (br) n_br_pend = stalled;
      if (!DCache_Busy) begin
        if (m_div_left > 0) begin
          n_div_left = m_div_left - 1;
          n_div_done = (n_div_left == 0);
        end else if (m_div_done) begin
          n_div_done = 1'b0;
        end else if (EXE_IsDiv) begin
          n_div_left = DIV_CYCLES - 1;
        end
      end
    end
  endtask

  task automatic model_commit();
    m_exc_pend = n_exc_pend; m_br_pend = n_br_pend;
    m_div_done = n_div_done; m_div_left = n_div_left;
  endtask

  // One clock: sample at the falling edge, advance the model on the rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    model_eval();
    last_v = got_v;
    check(tag, 32'(got_v), 32'(exp_v));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_idle();
    ICache_Busy = 1'b0; DCache_Busy = 1'b0; EXE_IsLoad = 1'b0; EXE_IsDiv = 1'b0;
    EXE_BrRedirect = 1'b0; MEM_ExcValid = 1'b0;
    EXE_Dst = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0;
  endtask

  task automatic do_reset(input string tag);
    set_idle();
    rst = 1'b0;
    model_reset();
    #1;
    model_eval();
    check({tag, "_async"}, 32'(got_v), 32'(13'b1101010100000));
    @(negedge clk);
    check({tag, "_held"}, 32'(got_v), 32'(exp_v));
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int n_start, n_busy, n_exe_stall, n_sel, n_wbfl;
    set_idle();
    rst = 1'b0;
    #3;
    do_reset("reset");
    step("idle");

    // Load-use hazard, then the same pattern with r0 as destination.
    EXE_IsLoad = 1'b1; EXE_Dst = 5'd5; ID_rs = 5'd5; ID_rt = 5'd9;
    step("load_use_rs");
    check("load_use_pc_wr", 32'(last_v[B_PC_WR]), 32'd0);
    check("load_use_exe_flush", 32'(last_v[B_EXE_FL]), 32'd1);
    ID_rs = 5'd1; ID_rt = 5'd5;
    step("load_use_rt");
    EXE_Dst = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0;
    step("load_r0_no_stall");
    check("load_r0_id_wr", 32'(last_v[B_ID_WR]), 32'd1);
    set_idle();

    // Full divide: exactly one start, DIV_CYCLES-1 busy, DIV_CYCLES EXE stall cycles.
    n_start = 0; n_busy = 0; n_exe_stall = 0;
    EXE_IsDiv = 1'b1;
    for (int i = 0; i < DIV_CYCLES + 1; i++) begin
      step("div_seq");
      n_start     += int'(last_v[B_DIV_START]);
      n_busy      += int'(last_v[B_DIV_BUSY]);
      n_exe_stall += int'(!last_v[B_EXE_WR]);
    end
    check("div_done_exe_wr", 32'(last_v[B_EXE_WR]), 32'd1);
    EXE_IsDiv = 1'b0;
    step("div_after");
    check("div_start_count", 32'(n_start), 32'd1);
    check("div_busy_count", 32'(n_busy), 32'(DIV_CYCLES - 1));
    check("div_exe_stall_count", 32'(n_exe_stall), 32'(DIV_CYCLES));

    // Exception while the I-cache is busy for four cycles.
    n_sel = 0;
    MEM_ExcValid = 1'b1; ICache_Busy = 1'b1;
    step("exc_c0");
    check("exc_c0_flush", 32'(last_v[B_MEM_FL]), 32'd1);
    MEM_ExcValid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step("exc_pend");
      n_sel += int'(last_v[B_SEL_EXC]);
      check("exc_pend_id_flush", 32'(last_v[B_ID_FL]), 32'd1);
    end
    ICache_Busy = 1'b0;
    step("exc_c4");
    n_sel += int'(last_v[B_SEL_EXC]);
    check("exc_c4_pc_wr", 32'(last_v[B_PC_WR]), 32'd1);
    check("exc_sel_count", 32'(n_sel), 32'd1);
    step("exc_after");

    // Branch held off by a two-cycle D-cache stall.
    n_sel = 0; n_wbfl = 0;
    EXE_BrRedirect = 1'b1; DCache_Busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step("br_dstall");
      n_sel  += int'(last_v[B_SEL_BR]);
      n_wbfl += int'(last_v[B_WB_FL]);
    end
    EXE_BrRedirect = 1'b0; DCache_Busy = 1'b0;
    step("br_release");
    check("br_release_sel", 32'(last_v[B_SEL_BR]), 32'd1);
    check("br_release_id_flush", 32'(last_v[B_ID_FL]), 32'd1);
    check("br_stall_sel", 32'(n_sel), 32'd0);
    check("br_stall_wb_flush", 32'(n_wbfl), 32'd2);
    step("br_after");

    // Exception arriving mid-divide (counter at 10) kills the divider.
    EXE_IsDiv = 1'b1;
    step("div_exc_start");
    step("div_exc_run");
    MEM_ExcValid = 1'b1;
    step("div_exc_hit");
    MEM_ExcValid = 1'b0; EXE_IsDiv = 1'b0;
    step("div_exc_after");
    check("div_exc_busy", 32'(last_v[B_DIV_BUSY]), 32'd0);

    // Reset while dividing and while an exception is pending.
    EXE_IsDiv = 1'b1;
    for (int i = 0; i < 3; i++) step("rst_div_run");
    do_reset("rst_div");
    step("rst_div_release");
    check("rst_div_no_start", 32'(last_v[B_DIV_START]), 32'd0);
    MEM_ExcValid = 1'b1; ICache_Busy = 1'b1;
    step("rst_exc_c0");
    MEM_ExcValid = 1'b0;
    step("rst_exc_pend");
    do_reset("rst_exc");
    step("rst_exc_release");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      ICache_Busy    = ($urandom_range(0, 99) < 25);
      DCache_Busy    = ($urandom_range(0, 99) < 15);
      EXE_IsLoad     = ($urandom_range(0, 99) < 30);
      EXE_IsDiv      = ($urandom_range(0, 99) < 6);
      EXE_BrRedirect = ($urandom_range(0, 99) < 15);
      MEM_ExcValid   = ($urandom_range(0, 99) < 4);
      EXE_Dst        = 5'($urandom_range(0, 3));
      ID_rs          = 5'($urandom_range(0, 3));
      ID_rt          = 5'($urandom_range(0, 3));
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
